// File: rtl/ps2_host_transmitter_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
// Optional feature macro: PS2_TX_ACK_CHECK_EN (device ACK bit selects sent/error).
package ps2_host_transmitter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SEND,
        ACK,
        RELEASE
    } tx_state_t;

    localparam int BIT_CNT_W = 4;

    // Falling-edge numbering: the edge leaving REQUEST is edge 0,
    // data bits go out on edges 1..8, parity on 9, stop on 10, ACK read on 11.
    localparam logic [BIT_CNT_W-1:0] LAST_BIT_EDGE   = 4'd8;
    localparam logic [BIT_CNT_W-1:0] PARITY_EDGE     = 4'd9;
    localparam logic [BIT_CNT_W-1:0] FINAL_DATA_EDGE = 4'd10;
    localparam logic [BIT_CNT_W-1:0] ACK_EDGE        = 4'd11;

    // Odd parity: set when the byte has an even number of ones.
    function automatic logic odd_parity(input logic [7:0] value);
        return ~(^value);
    endfunction

endpackage

// File: rtl/ps2_host_transmitter_line_sync.sv
// Line conditioning for the PS/2 transmitter: 2-flop synchronizers on the
// PS/2 clock and data lines, PS/2 clock falling-edge detect and the
// peripheral_clock timebase rising-edge detect.
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic peripheral_clock,
    input  logic device_clock,
    input  logic device_data,
    output logic clock_sync,
    output logic data_sync,
    output logic clock_fall,
    output logic peripheral_rise
);

    logic [1:0] clock_ff;
    logic [1:0] data_ff;
    logic [1:0] periph_ff;
    logic       clock_prev;

    // Synchronizer chains plus one history flop on the synchronized clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clock_ff   <= 2'b00;
            data_ff    <= 2'b00;
            periph_ff  <= 2'b00;
            clock_prev <= 1'b0;
        end else begin
            clock_ff   <= {clock_ff[0], device_clock};
            data_ff    <= {data_ff[0], device_data};
            periph_ff  <= {periph_ff[0], peripheral_clock};
            clock_prev <= clock_ff[1];
        end
    end

    assign clock_sync      = clock_ff[1];
    assign data_sync       = data_ff[1];
    assign clock_fall      = clock_prev & ~clock_ff[1];
    assign peripheral_rise = periph_ff[0] & ~periph_ff[1];

endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host transmitter: inhibits the bus, requests to send, shifts out a
// command byte with odd parity on device clock falling edges and waits for
// the line release. Define PS2_TX_ACK_CHECK_EN to let the device ACK bit
// choose between sent_flag and error_flag.
module ps2_host_transmitter
    import ps2_host_transmitter_pkg::*;
#(
    parameter logic [15:0] INHIBIT_TIME = 16'd100,
    parameter logic [15:0] OVER_TIME    = 16'd1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       peripheral_clock,
    input  logic       device_clock,
    input  logic       device_data,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       clock_drive_low,
    output logic       data_drive_low,
    output logic       sent_flag,
    output logic       error_flag
);

    logic clock_sync, data_sync, clock_fall, peripheral_rise;

    ps2_line_sync u_line_sync (
        .clock           (clock),
        .reset           (reset),
        .peripheral_clock(peripheral_clock),
        .device_clock    (device_clock),
        .device_data     (device_data),
        .clock_sync      (clock_sync),
        .data_sync       (data_sync),
        .clock_fall      (clock_fall),
        .peripheral_rise (peripheral_rise)
    );

    tx_state_t              state;
    logic [7:0]             shift;
    logic                   parity;
    logic                   ack_ok;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BIT_CNT_W-1:0]   bit_next;
    logic [15:0]            timer;
    logic                   timed;

    assign busy     = (state != IDLE);
    assign bit_next = bit_cnt + 4'd1;
    // States in which a silent device aborts the transfer.
    assign timed    = (state == REQUEST) || (state == SEND) ||
                      (state == ACK) || (state == RELEASE);

    // Transfer FSM with registered line drives and completion pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            shift           <= 8'h00;
            parity          <= 1'b0;
            ack_ok          <= 1'b0;
            bit_cnt         <= '0;
            timer           <= 16'd0;
            clock_drive_low <= 1'b0;
            data_drive_low  <= 1'b0;
            sent_flag       <= 1'b0;
            error_flag      <= 1'b0;
        end else begin
            sent_flag  <= 1'b0;
            error_flag <= 1'b0;
            if (timed && timer >= OVER_TIME) begin
                clock_drive_low <= 1'b0;
                data_drive_low  <= 1'b0;
                error_flag      <= 1'b1;
                state           <= IDLE;
            end else begin
                if (timed) begin
                    if (clock_fall)
                        timer <= 16'd0;
                    else if (peripheral_rise && timer < OVER_TIME)
                        timer <= timer + 16'd1;
                end
                case (state)
                    IDLE: if (tx_start) begin
                        shift           <= tx_data;
                        parity          <= odd_parity(tx_data);
                        bit_cnt         <= '0;
                        timer           <= 16'd0;
                        clock_drive_low <= 1'b1;
                        data_drive_low  <= 1'b0;
                        state           <= INHIBIT;
                    end
                    INHIBIT: begin
                        if (timer >= INHIBIT_TIME) begin
                            timer           <= 16'd0;
                            clock_drive_low <= 1'b0;
                            data_drive_low  <= 1'b1;
                            state           <= REQUEST;
                        end else if (peripheral_rise) begin
                            timer <= timer + 16'd1;
                        end
                    end
                    REQUEST: if (clock_fall) state <= SEND;
                    SEND: if (clock_fall) begin
                        bit_cnt <= bit_next;
                        if (bit_next <= LAST_BIT_EDGE) begin
                            data_drive_low <= ~shift[0];
                            shift          <= {1'b0, shift[7:1]};
                        end else if (bit_next == PARITY_EDGE) begin
                            data_drive_low <= ~parity;
                        end else if (bit_next == FINAL_DATA_EDGE) begin
                            data_drive_low <= 1'b0;
                            state          <= ACK;
                        end
                    end
                    ACK: if (clock_fall) begin
                        bit_cnt <= ACK_EDGE;
`ifdef PS2_TX_ACK_CHECK_EN
                        ack_ok  <= ~data_sync;
`else
                        ack_ok  <= 1'b1;
`endif
                        state   <= RELEASE;
                    end
                    RELEASE: if (clock_sync && data_sync) begin
                        sent_flag  <= ack_ok;
                        error_flag <= ~ack_ok;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter: a behavioural PS/2 device clocks
// frames out of the host, and frames, flags, inhibit length and timeout
// behaviour are compared against hand-computed values.
module tb_ps2_host_transmitter;

    logic       clock = 1'b0;
    logic       reset;
    logic       peripheral_clock = 1'b0;
    logic       device_clock, device_data;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy, clock_drive_low, data_drive_low, sent_flag, error_flag;

    logic dev_clk, dev_data;
    int   n_cmp = 0, n_mis = 0;
    int   sent_cnt = 0, err_cnt = 0, both_cnt = 0, rise_cnt = 0, inh_cnt = 0;

    // Open-drain bus: either side can pull a line low.
    assign device_clock = dev_clk & ~clock_drive_low;
    assign device_data  = dev_data & ~data_drive_low;

    ps2_host_transmitter dut (
        .clock           (clock),
        .reset           (reset),
        .peripheral_clock(peripheral_clock),
        .device_clock    (device_clock),
        .device_data     (device_data),
        .tx_data         (tx_data),
        .tx_start        (tx_start),
        .busy            (busy),
        .clock_drive_low (clock_drive_low),
        .data_drive_low  (data_drive_low),
        .sent_flag       (sent_flag),
        .error_flag      (error_flag)
    );

    always #5  clock = ~clock;
    always #40 peripheral_clock = ~peripheral_clock;

    always @(negedge clock) begin
        if (sent_flag)               sent_cnt++;
        if (error_flag)              err_cnt++;
        if (sent_flag && error_flag) both_cnt++;
    end

    always @(posedge peripheral_clock) begin
        rise_cnt++;
        if (clock_drive_low === 1'b1) inh_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start a transfer and act as the device for falling edges 0..last_edge.
    task automatic run_xfer(input logic [7:0] b, input bit ack_low, input int last_edge,
                            input bit inject, output logic [10:0] bits, output int fall_rises);
        bits = '1;
        fall_rises = 0;
        @(posedge peripheral_clock);
        repeat (3) @(negedge clock);
        tx_data = b; tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        for (int k = 0; k < 1200; k++) begin
            if (!clock_drive_low && data_drive_low) break;
            @(negedge clock);
        end
        chk("reach_request", {30'd0, clock_drive_low, data_drive_low}, 32'd1);
        for (int i = 0; i <= last_edge; i++) begin
            repeat (10) @(negedge clock);
            dev_clk = 1'b0;
            fall_rises = rise_cnt;
            repeat (10) @(negedge clock);
            if (i <= 10) bits[i] = device_data;
            if (inject && i == 4) begin
                tx_data = 8'hC1; tx_start = 1'b1;
                @(negedge clock);
                tx_start = 1'b0;
            end
            dev_clk = 1'b1;
            if (i == 10) dev_data = ack_low ? 1'b0 : 1'b1;
            if (i == 11) begin
                repeat (5) @(negedge clock);
                dev_data = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (!busy) break;
            @(negedge clock);
        end
        chk("idle_reached", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clock);
    endtask

    logic [10:0] bits;
    int s0, e0, i0, fr;

    initial begin
        reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cdl",  {31'd0, clock_drive_low}, 32'd0);
        chk("rst_ddl",  {31'd0, data_drive_low}, 32'd0);
        chk("rst_sent", {31'd0, sent_flag}, 32'd0);
        chk("rst_err",  {31'd0, error_flag}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
        s0 = sent_cnt; e0 = err_cnt;
        run_xfer(8'hED, 1'b1, 11, 1'b0, bits, fr);
        wait_idle(200);
        chk("ed_frame", {21'd0, bits}, {21'd0, 11'b1_1_11101101_0});
        chk("ed_sent", sent_cnt - s0, 1);
        chk("ed_err",  err_cnt - e0, 0);

        // 0xF4: parity 0, inhibit spans 100 timebase rises
        s0 = sent_cnt; i0 = inh_cnt;
        run_xfer(8'hF4, 1'b1, 11, 1'b0, bits, fr);
        wait_idle(200);
        chk("f4_inhibit", inh_cnt - i0, 100);
        chk("f4_parity", {31'd0, bits[9]}, 32'd0);
        chk("f4_frame", {21'd0, bits}, {21'd0, 11'b1_0_11110100_0});
        chk("f4_sent", sent_cnt - s0, 1);

        // Device NACK (data high on edge 11)
        s0 = sent_cnt; e0 = err_cnt;
        run_xfer(8'h12, 1'b0, 11, 1'b0, bits, fr);
        wait_idle(200);
        chk("nack_frame", {21'd0, bits}, {21'd0, 11'b1_1_00010010_0});
`ifdef PS2_TX_ACK_CHECK_EN
        chk("nack_sent", sent_cnt - s0, 0);
        chk("nack_err",  err_cnt - e0, 1);
`else
        chk("nack_sent", sent_cnt - s0, 1);
        chk("nack_err",  err_cnt - e0, 0);
`endif

        // Device stops clocking after edge 5 -> timeout
        s0 = sent_cnt; e0 = err_cnt;
        run_xfer(8'h9A, 1'b1, 5, 1'b0, bits, fr);
        wait_idle(9000);
        chk("to_rises_window", {31'd0, (rise_cnt - fr >= 999) && (rise_cnt - fr <= 1002)}, 32'd1);
        chk("to_err",  err_cnt - e0, 1);
        chk("to_sent", sent_cnt - s0, 0);
        chk("to_cdl",  {31'd0, clock_drive_low}, 32'd0);
        chk("to_ddl",  {31'd0, data_drive_low}, 32'd0);

        // Reset during SEND: edge 3 drives bit2 of 0xC3 (=0), so data is pulled low
        s0 = sent_cnt; e0 = err_cnt;
        run_xfer(8'hC3, 1'b1, 3, 1'b0, bits, fr);
        chk("mid_ddl_pre", {31'd0, data_drive_low}, 32'd1);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_cdl",  {31'd0, clock_drive_low}, 32'd0);
        chk("mid_rst_ddl",  {31'd0, data_drive_low}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("mid_rst_flags", (sent_cnt - s0) + (err_cnt - e0), 0);
        s0 = sent_cnt;
        run_xfer(8'h55, 1'b1, 11, 1'b0, bits, fr);
        wait_idle(200);
        chk("x55_frame", {21'd0, bits}, {21'd0, 11'b1_1_01010101_0});
        chk("x55_sent", sent_cnt - s0, 1);

        // tx_start with 0xC1 during SEND must not disturb 0x3C
        s0 = sent_cnt; e0 = err_cnt;
        run_xfer(8'h3C, 1'b1, 11, 1'b1, bits, fr);
        wait_idle(200);
        chk("inj_frame", {21'd0, bits}, {21'd0, 11'b1_1_00111100_0});
        chk("inj_sent", sent_cnt - s0, 1);
        chk("inj_err",  err_cnt - e0, 0);
        repeat (20) @(negedge clock);
        chk("inj_no_restart", {31'd0, busy}, 32'd0);

        chk("flags_exclusive", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ps2_host_transmitter.md
PS2_HOST_TRANSMITTER -- requirements
Module: ps2_host_transmitter

Interface
REQ-001 SHALL have parameter INHIBIT_TIME, default 16'd100: the number of peripheral_clock rising edges for which device_clock is held low before the start bit.
REQ-002 SHALL have parameter OVER_TIME, default 16'd1000: the number of peripheral_clock rising edges without a device_clock edge after which the transfer is aborted.
REQ-003 SHALL have port clock, input, 1 bit: system clock. All logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port peripheral_clock, input, 1 bit: slow timebase, sampled in the clock domain.
REQ-006 SHALL have port device_clock, input, 1 bit: raw PS/2 clock line level.
REQ-007 SHALL have port device_data, input, 1 bit: raw PS/2 data line level.
REQ-008 SHALL have port tx_data, input, 8 bits: command byte to send.
REQ-009 SHALL have port tx_start, input, 1 bit: one-cycle request to send tx_data.
REQ-010 SHALL have port busy, output, 1 bit: high while the state is not IDLE.
REQ-011 SHALL have port clock_drive_low, output, 1 bit: when 1, the open-drain pad pulls the PS/2 clock line low.
REQ-012 SHALL have port data_drive_low, output, 1 bit: when 1, the open-drain pad pulls the PS/2 data line low.
REQ-013 SHALL have port sent_flag, output, 1 bit: one-cycle pulse on successful completion.
REQ-014 SHALL have port error_flag, output, 1 bit: one-cycle pulse on NACK or timeout.

Function
REQ-015 SHALL synchronize device_clock and device_data through two flops each; "falling edge" means the synchronized clock went from 1 (previous cycle) to 0 (current cycle).
REQ-016 SHALL detect the peripheral_clock rising edge with a 2-flop delay, equivalent to the keyboard receiver's timebase detect.
REQ-017 SHALL implement the states IDLE, INHIBIT, REQUEST, SEND, ACK and RELEASE, with the transitions given in REQ-018 to REQ-024.
REQ-018 IDLE: when tx_start=1, SHALL latch tx_data, latch odd parity (the inverse of the XOR of the 8 bits), clear the bit counter and the timer, and go to INHIBIT on the next cycle. tx_start while busy=1 SHALL be ignored.
REQ-019 INHIBIT: SHALL drive clock_drive_low=1 and data_drive_low=0, and count peripheral_clock rising edges. When the count reaches INHIBIT_TIME, SHALL go to REQUEST.
REQ-020 REQUEST: SHALL drive data_drive_low=1 (start bit) and clock_drive_low=0. On the first falling edge, SHALL go to SEND.
REQ-021 SEND: on falling edges 1 to 8, SHALL drive data bits 0 to 7, LSB first, with data_drive_low = ~bit. Falling edge 9 SHALL drive the parity bit. Falling edge 10 SHALL release data (data_drive_low=0, stop bit) and go to ACK. Each output change SHALL take effect the cycle after the detected edge.
REQ-022 ACK: on falling edge 11, SHALL sample the synchronized data line and go to RELEASE. Per Configuration, a low sample is ACK and a high sample is NACK.
REQ-023 RELEASE: when the synchronized clock=1 and the synchronized data=1, SHALL pulse sent_flag (ACK) or error_flag (NACK) for one cycle and return to IDLE.
REQ-024 Timeout: in REQUEST, SEND, ACK and RELEASE, a 16-bit timer SHALL clear on every falling edge and otherwise increment on each peripheral_clock rising edge, saturating at OVER_TIME. When timer ≥ OVER_TIME, SHALL release both lines, pulse error_flag, and go to IDLE. Timeout SHALL take priority over every other transition.
REQ-025 Both drive outputs SHALL be 0 in IDLE. sent_flag and error_flag SHALL never be high in the same cycle.

Reset
REQ-026 Reset SHALL immediately force state=IDLE, busy=0, clock_drive_low=0, data_drive_low=0, sent_flag=0, error_flag=0, and clear all counters, the synchronizers and the latched byte. This applies mid-transfer, with no flag pulsed.

Configuration
REQ-027 With PS2_TX_ACK_CHECK_EN defined, the ACK-bit sample SHALL decide between sent_flag and error_flag as in REQ-022 and REQ-023.
REQ-028 Without PS2_TX_ACK_CHECK_EN, the ACK sample SHALL be ignored and every non-timeout transfer SHALL end with sent_flag.

Structure
REQ-029 A shared package SHALL hold the state enumeration, the 4-bit bit-count width, and the constants FINAL_DATA_EDGE=10 and ACK_EDGE=11.
REQ-030 One sub-module, ps2_line_sync, SHALL provide the 2-flop synchronizers, the falling-edge detect and the peripheral_clock edge detect.

Verification
REQ-031 tx_data=0xED, device model clocking with ACK low -> data line bits 1,0,1,1,0,1,1,1 then parity 1 then stop 1, followed by one sent_flag pulse.
REQ-032 tx_data=0xF4 -> parity bit 0 on edge 9; INHIBIT lasts exactly 100 peripheral_clock rising edges with clock_drive_low=1.
REQ-033 Device holds data high on edge 11: with PS2_TX_ACK_CHECK_EN -> error_flag pulse; without it -> sent_flag pulse.
REQ-034 Device stops clocking after edge 5 -> after 1000 peripheral_clock rising edges, error_flag pulse, both drives 0, busy=0.
REQ-035 Reset asserted during SEND -> drives 0 and busy 0 immediately, no flag pulsed; a new tx_start=0x55 then completes normally.
REQ-036 tx_start pulsed during SEND with a different byte -> ignored; the original byte completes unchanged.
